rx_clkdiv_cfg_ctrl: RTL and testbench

Reconfiguration sequencer for the RX clock divider. It accepts a prescale change request from the register file and decodes the one-hot prescale into a divide ratio. It then switches the divider at a safe period boundary: drain, gate, load, settle. The UART RX is held off while the switch is in progress, so it never samples on a truncated or glitched divided clock.

---
 rtl/rx_clkdiv_cfg_ctrl_if.sv | 25 ++
 rtl/rx_clkdiv_cfg_ctrl.sv | 123 ++++++++++++
 tb/tb_rx_clkdiv_cfg_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_clkdiv_cfg_ctrl_if.sv
// Configuration/divider-control bundle between the register file, the RX clock
// divider and the reconfiguration sequencer.
interface rx_clkdiv_cfg_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [5:0]       Prescale;
  logic             Cfg_Valid;
  logic             Cfg_Ready;
  logic             Div_Edge;
  logic [WIDTH-1:0] Div_Ratio;
  logic             Div_En;
  logic             RX_Hold;
  logic             Cfg_Err;
  logic             Cfg_Done;

  modport master (
    output Prescale, Cfg_Valid, Div_Edge,
    input  Cfg_Ready, Div_Ratio, Div_En, RX_Hold, Cfg_Err, Cfg_Done
  );

  modport slave (
    input  Prescale, Cfg_Valid, Div_Edge,
    output Cfg_Ready, Div_Ratio, Div_En, RX_Hold, Cfg_Err, Cfg_Done
  );
endinterface

// File: rtl/rx_clkdiv_cfg_ctrl.sv
// Sequencer that switches the RX clock divider ratio at a period boundary
// (drain, gate, load, settle) while holding the UART RX off.
module rx_clkdiv_cfg_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int DRAIN_TIMEOUT = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  rx_clkdiv_cfg_ctrl_if.slave   cfg
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SWITCH,
    ST_SETTLE,
    ST_DONE
  } state_t;

  localparam logic [7:0]       TO_LAST     = 8'(DRAIN_TIMEOUT - 1);
  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] RATIO_ONE   = WIDTH'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_div_ratio;
  logic [WIDTH-1:0] r_pending;
  logic [7:0]       r_to_cnt;
  logic [7:0]       r_settle_cnt;
  logic             r_cfg_err;

  logic [WIDTH-1:0] w_dec_val;
  logic             w_dec_err;
  logic             w_accept;
  logic             w_ready;
  logic             w_hold;
  logic             w_en;
  logic             w_done;

  // One-hot prescale decode; anything else falls back to ratio 1 and flags it.
  always_comb begin
    w_dec_val = RATIO_ONE;
    w_dec_err = 1'b0;
    case (cfg.Prescale)
      6'b100000: w_dec_val = WIDTH'(1);
      6'b010000: w_dec_val = WIDTH'(2);
      6'b001000: w_dec_val = WIDTH'(4);
      6'b000100: w_dec_val = WIDTH'(8);
      default:   w_dec_err = 1'b1;
    endcase
  end

  assign w_accept = cfg.Cfg_Valid && (r_state == ST_IDLE);

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_hold       = 1'b0;
    w_en         = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (w_accept) begin
          if (w_dec_val == r_div_ratio) w_state_next = ST_DONE;
          else                          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_hold = 1'b1;
        if (cfg.Div_Edge || (r_to_cnt == TO_LAST)) w_state_next = ST_SWITCH;
      end
      ST_SWITCH: begin
        w_hold       = 1'b1;
        w_en         = 1'b0;
        w_state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        w_hold = 1'b1;
        if (r_settle_cnt == SETTLE_LAST) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_div_ratio  <= RATIO_ONE;
      r_pending    <= '0;
      r_to_cnt     <= '0;
      r_settle_cnt <= '0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cfg_err <= w_accept && w_dec_err;
      if (w_accept) begin
        r_pending <= w_dec_val;
        r_to_cnt  <= '0;
      end
      if (r_state == ST_DRAIN) r_to_cnt <= r_to_cnt + 8'd1;
      // Ratio loads on the edge that ends the gated cycle, so it never moves while enabled.
      if (r_state == ST_SWITCH) begin
        r_div_ratio  <= r_pending;
        r_settle_cnt <= '0;
      end
      if (r_state == ST_SETTLE) r_settle_cnt <= r_settle_cnt + 8'd1;
    end
  end

  assign cfg.Cfg_Ready = w_ready;
  assign cfg.RX_Hold   = w_hold;
  assign cfg.Div_En    = w_en;
  assign cfg.Cfg_Done  = w_done;
  assign cfg.Cfg_Err   = r_cfg_err;
  assign cfg.Div_Ratio = r_div_ratio;

endmodule

// File: tb/tb_rx_clkdiv_cfg_ctrl.sv
// Directed bench for rx_clkdiv_cfg_ctrl: ratio change, same-ratio request,
// drain timeout, illegal encoding and asynchronous reset mid-sequence.
module tb_rx_clkdiv_cfg_ctrl;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  rx_clkdiv_cfg_ctrl_if #(.WIDTH(8)) bus ();

  rx_clkdiv_cfg_ctrl #(
    .WIDTH(8),
    .SETTLE_CYCLES(16),
    .DRAIN_TIMEOUT(255)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .cfg(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helper: issue one request, pulse Div_Edge early in DRAIN, wait for Cfg_Done.
  task automatic do_request(input logic [5:0] p);
    int lat;
    @(negedge clk);
    bus.Prescale  = p;
    bus.Cfg_Valid = 1'b1;
    @(negedge clk);
    bus.Cfg_Valid = 1'b0;
    lat = 1;
    while (!bus.Cfg_Done && lat < 400) begin
      bus.Div_Edge = (lat == 1);
      @(negedge clk);
      lat++;
    end
    bus.Div_Edge = 1'b0;
    n_tests++;
    if (lat >= 400) begin
      $display("FAIL setup_done_timeout: Cfg_Done not seen within %0d cycles", lat);
      n_fail++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus.Div_Ratio, bus.Div_En, bus.RX_Hold, bus.Cfg_Ready, bus.Cfg_Err, bus.Cfg_Done}
        !== {8'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      $display("FAIL reset_held: ratio=%0d en=%b hold=%b ready=%b err=%b done=%b, need 1 1 0 1 0 0",
               bus.Div_Ratio, bus.Div_En, bus.RX_Hold, bus.Cfg_Ready, bus.Cfg_Err, bus.Cfg_Done);
      n_fail++;
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if ({bus.Div_Ratio, bus.Div_En, bus.RX_Hold, bus.Cfg_Ready, bus.Cfg_Err, bus.Cfg_Done}
          !== {8'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
        $display("FAIL reset_idle[%0d]: ratio=%0d en=%b hold=%b ready=%b err=%b done=%b, need 1 1 0 1 0 0",
                 i, bus.Div_Ratio, bus.Div_En, bus.RX_Hold, bus.Cfg_Ready, bus.Cfg_Err, bus.Cfg_Done);
        n_fail++;
      end
    end
    $display("[TB] reset: %0d tests so far, %0d failed", n_tests, n_fail);
  endtask

  task automatic test_ratio_change();
    logic exp_done;
    @(negedge clk);
    bus.Prescale  = 6'b000100;
    bus.Cfg_Valid = 1'b1;
    @(negedge clk);
    bus.Cfg_Valid = 1'b0;
    bus.Prescale  = 6'b010000;  // late change must not be applied
    n_tests++;
    if ({bus.RX_Hold, bus.Cfg_Ready, bus.Div_En} !== 3'b101) begin
      $display("FAIL drain_entry: hold=%b ready=%b en=%b, need 1 0 1",
               bus.RX_Hold, bus.Cfg_Ready, bus.Div_En);
      n_fail++;
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_tests++;
      if ({bus.Div_En, bus.RX_Hold, bus.Div_Ratio} !== {1'b1, 1'b1, 8'd1}) begin
        $display("FAIL drain_wait[%0d]: en=%b hold=%b ratio=%0d, need 1 1 1",
                 k, bus.Div_En, bus.RX_Hold, bus.Div_Ratio);
        n_fail++;
      end
      if (k == 6) bus.Div_Edge = 1'b1;
    end
    @(negedge clk);
    bus.Div_Edge = 1'b0;
    n_tests++;
    if ({bus.Div_En, bus.RX_Hold, bus.Div_Ratio} !== {1'b0, 1'b1, 8'd1}) begin
      $display("FAIL switch_cycle: en=%b hold=%b ratio=%0d, need 0 1 1",
               bus.Div_En, bus.RX_Hold, bus.Div_Ratio);
      n_fail++;
    end
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      exp_done = (i == 17);
      n_tests++;
      if ({bus.Cfg_Done, bus.RX_Hold, bus.Div_En, bus.Div_Ratio} !== {exp_done, ~exp_done, 1'b1, 8'd8}) begin
        $display("FAIL settle_done[%0d]: done=%b hold=%b en=%b ratio=%0d, need %b %b 1 8",
                 i, bus.Cfg_Done, bus.RX_Hold, bus.Div_En, bus.Div_Ratio, exp_done, ~exp_done);
        n_fail++;
      end
    end
    @(negedge clk);
    n_tests++;
    if ({bus.Cfg_Ready, bus.Cfg_Done, bus.RX_Hold} !== 3'b100) begin
      $display("FAIL ready_return: ready=%b done=%b hold=%b, need 1 0 0",
               bus.Cfg_Ready, bus.Cfg_Done, bus.RX_Hold);
      n_fail++;
    end
    $display("[TB] ratio_change: %0d tests so far, %0d failed", n_tests, n_fail);
  endtask

  task automatic test_same_ratio();
    @(negedge clk);
    bus.Prescale  = 6'b000100;
    bus.Cfg_Valid = 1'b1;
    @(negedge clk);
    bus.Cfg_Valid = 1'b0;
    n_tests++;
    if ({bus.Cfg_Done, bus.RX_Hold, bus.Div_En, bus.Cfg_Ready, bus.Cfg_Err, bus.Div_Ratio}
        !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd8}) begin
      $display("FAIL same_ratio_done: done=%b hold=%b en=%b ready=%b err=%b ratio=%0d, need 1 0 1 0 0 8",
               bus.Cfg_Done, bus.RX_Hold, bus.Div_En, bus.Cfg_Ready, bus.Cfg_Err, bus.Div_Ratio);
      n_fail++;
    end
    @(negedge clk);
    n_tests++;
    if ({bus.Cfg_Ready, bus.Cfg_Done, bus.RX_Hold} !== 3'b100) begin
      $display("FAIL same_ratio_idle: ready=%b done=%b hold=%b, need 1 0 0",
               bus.Cfg_Ready, bus.Cfg_Done, bus.RX_Hold);
      n_fail++;
    end
    $display("[TB] same_ratio: %0d tests so far, %0d failed", n_tests, n_fail);
  endtask

  task automatic test_timeout();
    int n;
    int m;
    bus.Div_Edge = 1'b0;
    @(negedge clk);
    bus.Prescale  = 6'b010000;
    bus.Cfg_Valid = 1'b1;
    @(negedge clk);
    bus.Cfg_Valid = 1'b0;
    n = 0;
    while (bus.Div_En && n < 400) begin
      if (bus.RX_Hold) n++;
      @(negedge clk);
    end
    n_tests++;
    if (n != 255) begin
      $display("FAIL drain_timeout: %0d DRAIN cycles before SWITCH, need 255", n);
      n_fail++;
    end
    n_tests++;
    if (bus.Div_Ratio !== 8'd8) begin
      $display("FAIL timeout_switch_ratio: ratio=%0d during SWITCH, need 8", bus.Div_Ratio);
      n_fail++;
    end
    @(negedge clk);
    n_tests++;
    if (bus.Div_Ratio !== 8'd2) begin
      $display("FAIL timeout_new_ratio: ratio=%0d, need 2", bus.Div_Ratio);
      n_fail++;
    end
    m = 1;
    while (!bus.Cfg_Done && m < 40) begin
      @(negedge clk);
      m++;
    end
    n_tests++;
    if (m != 17) begin
      $display("FAIL timeout_done_latency: Cfg_Done %0d cycles after SWITCH, need 17", m);
      n_fail++;
    end
    @(negedge clk);
    $display("[TB] timeout: %0d tests so far, %0d failed", n_tests, n_fail);
  endtask

  task automatic test_illegal();
    int m;
    do_request(6'b001000);
    n_tests++;
    if (bus.Div_Ratio !== 8'd4) begin
      $display("FAIL illegal_setup_ratio: ratio=%0d, need 4", bus.Div_Ratio);
      n_fail++;
    end
    bus.Prescale  = 6'b110000;
    bus.Cfg_Valid = 1'b1;
    @(negedge clk);
    bus.Cfg_Valid = 1'b0;
    n_tests++;
    if ({bus.Cfg_Err, bus.RX_Hold} !== 2'b11) begin
      $display("FAIL illegal_err_pulse: err=%b hold=%b, need 1 1", bus.Cfg_Err, bus.RX_Hold);
      n_fail++;
    end
    @(negedge clk);
    n_tests++;
    if (bus.Cfg_Err !== 1'b0) begin
      $display("FAIL illegal_err_width: err=%b on 2nd cycle, need 0", bus.Cfg_Err);
      n_fail++;
    end
    bus.Div_Edge = 1'b1;
    @(negedge clk);
    bus.Div_Edge = 1'b0;
    n_tests++;
    if (bus.Div_En !== 1'b0) begin
      $display("FAIL illegal_switch: en=%b, need 0", bus.Div_En);
      n_fail++;
    end
    m = 0;
    while (!bus.Cfg_Done && m < 40) begin
      @(negedge clk);
      m++;
    end
    n_tests++;
    if ({bus.Cfg_Done, bus.Div_Ratio} !== {1'b1, 8'd1}) begin
      $display("FAIL illegal_final_ratio: done=%b ratio=%0d, need 1 1", bus.Cfg_Done, bus.Div_Ratio);
      n_fail++;
    end
    @(negedge clk);
    // Illegal encoding while already at ratio 1 takes the same-ratio path.
    bus.Prescale  = 6'b000000;
    bus.Cfg_Valid = 1'b1;
    @(negedge clk);
    bus.Cfg_Valid = 1'b0;
    n_tests++;
    if ({bus.Cfg_Err, bus.Cfg_Done, bus.RX_Hold, bus.Div_En} !== 4'b1101) begin
      $display("FAIL illegal_same_ratio: err=%b done=%b hold=%b en=%b, need 1 1 0 1",
               bus.Cfg_Err, bus.Cfg_Done, bus.RX_Hold, bus.Div_En);
      n_fail++;
    end
    @(negedge clk);
    $display("[TB] illegal: %0d tests so far, %0d failed", n_tests, n_fail);
  endtask

  task automatic test_reset_mid();
    int bad;
    @(negedge clk);
    bus.Prescale  = 6'b000100;
    bus.Cfg_Valid = 1'b1;
    @(negedge clk);
    bus.Prescale  = 6'b010000;  // second request issued while busy
    n_tests++;
    if ({bus.Cfg_Ready, bus.RX_Hold} !== 2'b01) begin
      $display("FAIL busy_drain: ready=%b hold=%b, need 0 1", bus.Cfg_Ready, bus.RX_Hold);
      n_fail++;
    end
    @(negedge clk);
    bus.Div_Edge = 1'b1;
    @(negedge clk);
    bus.Cfg_Valid = 1'b0;
    bus.Div_Edge  = 1'b0;
    n_tests++;
    if (bus.Div_En !== 1'b0) begin
      $display("FAIL busy_switch: en=%b, need 0", bus.Div_En);
      n_fail++;
    end
    repeat (5) @(negedge clk);
    n_tests++;
    if ({bus.Div_Ratio, bus.RX_Hold} !== {8'd8, 1'b1}) begin
      $display("FAIL busy_request_ignored: ratio=%0d hold=%b, need 8 1", bus.Div_Ratio, bus.RX_Hold);
      n_fail++;
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.Div_Ratio, bus.Div_En, bus.RX_Hold, bus.Cfg_Ready, bus.Cfg_Done, bus.Cfg_Err}
        !== {8'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      $display("FAIL async_reset: ratio=%0d en=%b hold=%b ready=%b done=%b err=%b, need 1 1 0 1 0 0",
               bus.Div_Ratio, bus.Div_En, bus.RX_Hold, bus.Cfg_Ready, bus.Cfg_Done, bus.Cfg_Err);
      n_fail++;
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if ({bus.Cfg_Done, bus.Cfg_Ready, bus.Div_Ratio} !== {1'b0, 1'b1, 8'd1}) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      $display("FAIL post_reset_quiet: %0d cycles with done/ready/ratio wrong, need 0", bad);
      n_fail++;
    end
    $display("[TB] reset_mid: %0d tests so far, %0d failed", n_tests, n_fail);
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.Prescale  = 6'b100000;
    bus.Cfg_Valid = 1'b0;
    bus.Div_Edge  = 1'b0;
    test_reset();
    test_ratio_change();
    test_same_ratio();
    test_timeout();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
